// File: rtl/figo_pkg.sv
// figo_pkg: shared definitions for the move transmitter.
//   - 3-bit room encodings and the room-valid check
//   - step-symbol table, keyed by the room being left
//   - transmitter state enum and counter widths
package figo_pkg;

    localparam int unsigned ROOM_W = 3;
    localparam int unsigned STEP_W = 2;
    localparam int unsigned CNT_W  = 8;

    localparam logic [ROOM_W-1:0] ROOM0 = 3'd0;
    localparam logic [ROOM_W-1:0] ROOM1 = 3'd1;
    localparam logic [ROOM_W-1:0] ROOM2 = 3'd2;
    localparam logic [ROOM_W-1:0] ROOM3 = 3'd3;

    // One step command: first is sent before second on the serial line.
    typedef struct packed {
        logic first;
        logic second;
    } symbol_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BIT1,
        ST_BIT2,
        ST_WAIT_ACK,
        ST_DONE,
        ST_ERR
    } tx_state_t;

    // Symbol that moves the controller out of room src.
    function automatic symbol_t step_symbol(input logic [STEP_W-1:0] src);
        symbol_t s;
        unique case (src)
            2'd0:    s = symbol_t'(2'b10);
            2'd1:    s = symbol_t'(2'b00);
            2'd2:    s = symbol_t'(2'b11);
            default: s = symbol_t'(2'b01);
        endcase
        return s;
    endfunction

    // Codes 4..7 on the controller room report are invalid.
    function automatic logic room_valid(input logic [ROOM_W-1:0] room);
        return room <= ROOM3;
    endfunction

endpackage

// File: rtl/figo_move_tx_if.sv
// figo_move_tx_if: request channel, controller link and status of the
// move transmitter.
//   master: requester/controller side (drives req_valid, req_room, cur_room)
//   slave : transmitter side (drives req_ready, input_data, busy, done, err)
interface figo_move_tx_if;
    import figo_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [STEP_W-1:0]   req_room;
    logic [ROOM_W-1:0]   cur_room;
    logic                input_data;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output req_valid, req_room, cur_room,
        input  req_ready, input_data, busy, done, err
    );

    modport slave (
        input  req_valid, req_room, cur_room,
        output req_ready, input_data, busy, done, err
    );

endinterface

// File: rtl/figo_bit_timer.sv
// figo_bit_timer: reloadable down-counter shared by bit-period and
// ack-timeout timing.
//   clk, reset   : clock, async active-low reset
//   load         : reload counter with load_val (takes priority)
//   load_val     : number of clocks until expire_c
//   expire_c     : high for one cycle, the last clock of the loaded period
module figo_bit_timer
    import figo_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire_c
);

    logic [CNT_W-1:0] cnt;

    // Count down to zero and park there until the next reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // A load of N at the state-entry edge lets the owner leave N edges later.
    assign expire_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/figo_move_tx.sv
// figo_move_tx: walks the room controller from its current room to a
// requested room, sending one 2-bit serial symbol per step and waiting
// for the controller's room report to advance after each symbol.
//   clk, reset : clock, async active-low reset
//   bus        : figo_move_tx_if.slave (request channel, cur_room input,
//                input_data serial output, busy/done/err status)
// Parameters: BIT_CYCLES (clocks per serial bit), ACK_TIMEOUT (clocks
// allowed for the room report to advance after a symbol).
module figo_move_tx
    import figo_pkg::*;
#(
    parameter int unsigned BIT_CYCLES  = 1,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    figo_move_tx_if.slave bus
);

    tx_state_t          state;
    tx_state_t          state_next;

    logic [ROOM_W-1:0]  src_room;
    logic [STEP_W-1:0]  tgt_room;
    logic [STEP_W-1:0]  steps_left;

    logic [STEP_W-1:0]  steps_c;
    logic [STEP_W-1:0]  exp_room_c;
    logic               accept_c;
    logic               ack_c;
    logic               room_bad_c;
    symbol_t            sym_c;

    logic               tmr_load_c;
    logic [CNT_W-1:0]   tmr_val_c;
    logic               tmr_expire_c;

    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               data_q;

    assign accept_c   = bus.req_valid && ready_q && (state == ST_IDLE);
    // Ring distance; 2-bit subtraction wraps room 3 back to room 0.
    assign steps_c    = tgt_room - src_room[STEP_W-1:0];
    assign exp_room_c = src_room[STEP_W-1:0] + STEP_W'(1);
    assign room_bad_c = !room_valid(bus.cur_room);
    assign ack_c      = (bus.cur_room == {1'b0, exp_room_c});
    assign sym_c      = step_symbol(src_room[STEP_W-1:0]);

    figo_bit_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .expire_c (tmr_expire_c)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and timer reload decode.
    always_comb begin
        state_next = state;
        tmr_load_c = 1'b0;
        tmr_val_c  = CNT_W'(BIT_CYCLES);

        unique case (state)
            ST_IDLE: begin
                if (accept_c) state_next = ST_LOAD;
            end
            // An invalid starting room wins over a zero-step request.
            ST_LOAD: begin
                if (!room_valid(src_room))  state_next = ST_ERR;
                else if (steps_c == '0)     state_next = ST_DONE;
                else                        state_next = ST_BIT1;
            end
            ST_BIT1: begin
                if (tmr_expire_c) state_next = ST_BIT2;
            end
            ST_BIT2: begin
                if (tmr_expire_c) state_next = ST_WAIT_ACK;
            end
            // A matching report on the timeout clock still counts as an ack.
            ST_WAIT_ACK: begin
                if (room_bad_c)                    state_next = ST_ERR;
                else if (ack_c)                    state_next = (steps_left == STEP_W'(1)) ? ST_DONE : ST_BIT1;
                else if (tmr_expire_c)             state_next = ST_ERR;
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_ERR:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        // Reload on entry to every timed state.
        if ((state_next != state) &&
            ((state_next == ST_BIT1) || (state_next == ST_BIT2) || (state_next == ST_WAIT_ACK))) begin
            tmr_load_c = 1'b1;
        end
        if (state_next == ST_WAIT_ACK) begin
            tmr_val_c = CNT_W'(ACK_TIMEOUT);
        end
    end

    // Move context: endpoints latched on accept, source advanced per ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_room   <= ROOM0;
            tgt_room   <= '0;
            steps_left <= '0;
        end else begin
            if (accept_c) begin
                src_room <= bus.cur_room;
                tgt_room <= bus.req_room;
            end
            if (state == ST_LOAD) begin
                steps_left <= steps_c;
            end
            if ((state == ST_WAIT_ACK) && ack_c) begin
                src_room   <= {1'b0, exp_room_c};
                steps_left <= steps_left - STEP_W'(1);
            end
        end
    end

    // Registered outputs. Status and serial data follow the state one clock
    // later; req_ready is decoded from the next state so a request can never
    // be accepted twice.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 1'b0;
        end else begin
            ready_q <= (state_next == ST_IDLE);
            busy_q  <= (state != ST_IDLE);
            done_q  <= (state == ST_DONE);
            err_q   <= (state == ST_ERR);
            unique case (state)
                ST_BIT1: data_q <= sym_c.first;
                ST_BIT2: data_q <= sym_c.second;
                default: data_q <= 1'b0;
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.input_data = data_q;

endmodule

// File: doc/figo_move_tx.md
FIGO_MOVE_TX -- requirements
Module: figo_move_tx

Interface
REQ-001 Parameter BIT_CYCLES, default 1: clocks each serial bit is held on input_data (legal range 1..255).
REQ-002 Parameter ACK_TIMEOUT, default 16: clocks allowed for the controller's room report to advance after a symbol (legal range 1..255).
REQ-003 clk  in  1  single clock; all flops rise-edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  move request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_room  in  2  target room 0..3.
REQ-008 cur_room  in  3  room reported by the controller (its next_state); values 4..7 are invalid.
REQ-009 input_data  out  1  serial command line to the controller; idle level 0.
REQ-010 busy  out  1  move in progress.
REQ-011 done  out  1  one-cycle pulse: target reached.
REQ-012 err  out  1  one-cycle pulse: move aborted.

Function
REQ-013 A request SHALL be accepted on a clock edge where req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-014 On accept, req_room SHALL be latched, and steps = (req_room - cur_room[1:0]) mod 4 SHALL be computed.
  - The ring wraps: room 3 is followed by room 0.
REQ-015 Each step SHALL be sent as a 2-bit symbol, first bit then second bit, selected by the room being left:
  - R0: 1,0
  - R1: 0,0
  - R2: 1,1
  - R3: 0,1
REQ-016 Each symbol bit SHALL be driven for exactly BIT_CYCLES clocks.
REQ-017 FSM states are IDLE, LOAD, BIT1, BIT2, WAIT_ACK, DONE and ERR, with these transitions:
  - IDLE->LOAD on accept.
  - LOAD->DONE if steps=0; LOAD->ERR if cur_room>3; otherwise LOAD->BIT1.
  - BIT1->BIT2 and BIT2->WAIT_ACK, each after BIT_CYCLES clocks.
  - WAIT_ACK->BIT1 when cur_room equals the expected room (source+1 mod 4) and steps remain.
  - WAIT_ACK->DONE when cur_room equals the expected room and it is the last step.
  - WAIT_ACK->ERR after ACK_TIMEOUT clocks without a match, or immediately if cur_room>3.
  - DONE->IDLE and ERR->IDLE after one cycle.
REQ-018 input_data SHALL be 0 in IDLE, LOAD, WAIT_ACK, DONE and ERR.
REQ-019 done SHALL be 1 only in DONE; err SHALL be 1 only in ERR; the two SHALL never be 1 in the same cycle.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Latency: the first symbol bit SHALL appear 2 clocks after the accept edge.
  - A zero-step request SHALL pulse done 2 clocks after accept and drive no symbols.
REQ-022 req_valid and req_room SHALL be ignored while busy; a request held across DONE/ERR SHALL be accepted once the block returns to IDLE.
REQ-023 An unexpected cur_room change during BIT1/BIT2 SHALL NOT affect output; it is evaluated only in WAIT_ACK.

Reset
REQ-024 While reset=0, the block SHALL be in IDLE with input_data=0, busy=0, done=0, err=0, req_ready=0, and all counters cleared.
REQ-025 req_ready SHALL go to 1 on the first clock edge after reset is released.
REQ-026 Reset asserted mid-symbol SHALL force input_data to 0 asynchronously; the partial symbol SHALL NOT be resumed.

Structure
REQ-027 Shared package figo_pkg SHALL hold:
  - room encodings ROOM0..ROOM3 (3-bit);
  - the step-symbol table from REQ-015;
  - the tx state enum;
  - the room-valid check.
REQ-028 Sub-module figo_bit_timer SHALL provide a reloadable down-counter.
  - It is used for both the BIT_CYCLES bit period and the ACK_TIMEOUT wait.
  - It outputs an expire pulse.

Verification
REQ-029 Bench: cur_room=0, request room 1, with a controller model that steps on each symbol -> input_data 1,0, then done pulse; input_data 0 afterwards.
REQ-030 Bench: cur_room=2, request room 1 (steps=3, wraps) -> symbols 11, 01, 10 in order, cur_room sequence 3,0,1, then done.
REQ-031 Bench: cur_room=3, request room 3 -> done exactly 2 clocks after accept, input_data stays 0, no symbols.
REQ-032 Bench: BIT_CYCLES=3, ACK_TIMEOUT=4, model never advances -> each bit held 3 clocks, err pulses 4 clocks into WAIT_ACK, then req_ready=1.
REQ-033 Bench: reset=0 asserted during BIT2 of a 2-step move -> input_data=0 immediately; after release, req_ready=1 and a new request completes normally.
REQ-034 Bench: cur_room=5 at accept -> err pulse, no symbols; a req_valid pulse while busy is not accepted.
